spi_slave_byte: RTL

- Byte-oriented SPI slave (mode 0, MSB first) clocked by fclk; it is the responder end of the byte-wide SPI master protocol used for the SD link.
- Serves the expansion-connector SPI port, so an external master (second board or AVR) can exchange bytes with FPGA-internal logic.
- SCK/CS_n/MOSI are asynchronous and synchronised and edge-detected on fclk. Requirement: each SCK half-period ≥ (SYNC_STAGES+2) fclk cycles.
- Internal side: received byte plus one-cycle strobe; single-entry TX holding register with load/taken handshake.

---
 rtl/spi_slave_byte.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_byte.sv
// Byte-oriented SPI mode-0 slave, MSB first, oversampled on fclk.
// Exchanges one byte per 8 SCK cycles with a single-entry TX holding register.
module spi_slave_byte #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL        = 8'hFF
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full,
  output logic       tx_taken,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       frame_start,
  output logic       frame_end
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic                   cs_d, sck_d;
  logic [7:0]             hold;
  logic [7:0]             tx_shift, rx_shift;
  logic [2:0]             bit_cnt;

  logic       cs_now, sck_now, mosi_s;
  logic       cs_fall, cs_rise, sck_rise, sck_fall;
  logic       do_reload;
  logic       load_take;
  logic [7:0] load_byte;

  // NOTE: CS_n synchronises out of reset as "selected"; a CS held low across
  // reset release then produces no falling edge and cannot open a frame.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the value from
      // before this edge, which is what makes this a chain rather than one flop.
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_now   = cs_sync[SYNC_STAGES-1];
  assign sck_now  = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_now;
  assign cs_rise  = ~cs_d & cs_now;
  assign sck_rise = ~sck_d & sck_now;
  assign sck_fall = sck_d & ~sck_now;

  // Byte boundaries: frame open, or the SCK fall that follows the 8th rise.
  assign do_reload = (state == IDLE) ? cs_fall
                                     : (!cs_rise && sck_fall && bit_cnt == 3'd0);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    load_byte = FILL;
    load_take = 1'b0;
    if (tx_full) begin
      load_byte = hold;
      load_take = 1'b1;
    end else if (tx_load) begin
      load_byte = tx_data;
      load_take = 1'b1;
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= 8'h00;
      tx_full     <= 1'b0;
      tx_shift    <= 8'h00;
      rx_shift    <= 8'h00;
      bit_cnt     <= 3'd0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
      tx_taken    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_data     <= 8'h00;
      rx_stb      <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      tx_taken    <= do_reload & load_take;
      tx_underrun <= do_reload & ~load_take;
      rx_stb      <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;

      // A same-cycle load during a reload from a full register refills it.
      if (do_reload) begin
        tx_shift <= load_byte;
        spi_miso <= load_byte[7];
        if (tx_full) begin
          if (tx_load) hold <= tx_data;
          else         tx_full <= 1'b0;
        end
      end else if (tx_load) begin
        hold    <= tx_data;
        tx_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            frame_start <= 1'b1;
            bit_cnt     <= 3'd0;
            spi_miso_oe <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_end   <= 1'b1;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b1;
            bit_cnt     <= 3'd0;
            state       <= IDLE;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data <= {rx_shift[6:0], mosi_s};
              rx_stb  <= 1'b1;
            end
          end else if (sck_fall && bit_cnt != 3'd0) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            spi_miso <= tx_shift[6];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
